// File: rtl/mem_pkg.sv
// mem_pkg
// Shared types and constants for the main-memory responder slice.
//   state_t         : responder FSM states
//   LINE_BITS       : width of one cache line (512)
//   WORDS_PER_LINE  : 32-bit words per line (16)
//   OFFSET_BITS     : byte-offset bits inside a line (6)
//   STAT_W          : width of the completed-read/write statistics counters
//   word_index()    : byte address -> RAM word index, aliased modulo the depth
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    RESP
  } state_t;

  localparam int LINE_BITS      = 512;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_BITS    = 6;
  localparam int STAT_W         = 16;

  // Drops the byte offset inside a word and folds the result into the RAM
  // depth, so any address beyond the RAM silently aliases onto it.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth_words);
    return (addr >> 2) & (depth_words - 32'd1);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram
// Single-port 32-bit word RAM with synchronous read and synchronous write.
// Ports:
//   clk   : clock, rising edge
//   en    : access enable for this cycle
//   we    : write enable (only meaningful with en)
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
// Contents are not affected by any reset; every word starts at INIT_WORD.
module mem_word_ram #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0002,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  // A write does not also refresh rdata; the responder never reads back the
  // word it is writing in the same cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder
// Main-memory slave answering 512-bit line-fill reads and 32-bit word writes
// after a programmable access latency.
// Ports:
//   clk, rst_n          : clock (rising edge) and async active-low reset
//   main_mem_addr       : request byte address
//   main_mem_data_out   : write data from the controller
//   main_mem_read_req   : line-read request (level)
//   main_mem_write_req  : word-write request (level)
//   main_mem_data_in    : returned line, word i in bits [32i+31:32i]
//   main_mem_ready      : one-cycle completion pulse
//   busy                : high whenever the FSM is not idle
//   rd_count, wr_count  : wrapping counts of completed reads / writes
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 4,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0002
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          main_mem_addr,
  input  logic [31:0]          main_mem_data_out,
  input  logic                 main_mem_read_req,
  input  logic                 main_mem_write_req,
  output logic [LINE_BITS-1:0] main_mem_data_in,
  output logic                 main_mem_ready,
  output logic                 busy,
  output logic [STAT_W-1:0]    rd_count,
  output logic [STAT_W-1:0]    wr_count
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [15:0] LAST_WAIT  = 16'(LATENCY - 1);
  localparam logic [15:0] LAST_BEAT  = 16'(WORDS_PER_LINE);

  state_t               state;
  logic [15:0]          cnt;
  logic [AW-1:0]        word_idx;
  logic [31:0]          wdata_q;
  logic                 op_read;
  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] line_next;
  logic [3:0]           lane;

  logic                 ram_en;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [31:0]          ram_rdata;
  logic [AW-1:0]        req_idx;

  assign req_idx        = AW'(word_index(main_mem_addr, DEPTH_WORDS));
  assign main_mem_ready = (state == RESP);
  assign busy           = (state != IDLE);

  mem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_WORD   (INIT_WORD),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // RAM port control. Burst beats 0..15 issue reads at the line base with the
  // beat number in the low four index bits. The write strobe is tied to the
  // state, so an async reset before the last wait cycle ends drops the write.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = word_idx;
    if (state == RD_BURST && cnt < LAST_BEAT) begin
      ram_en   = 1'b1;
      ram_addr = {word_idx[AW-1:4], cnt[3:0]};
    end
    if (state == WR_WAIT && cnt == LAST_WAIT) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end
  end

  // Read data lags issue by one cycle, so beat k captures word k-1. At beat 16
  // the lane wraps to 15, which is the final capture.
  always_comb begin
    lane      = cnt[3:0] - 4'd1;
    line_next = line_q;
    line_next[{lane, 5'b0} +: 32] = ram_rdata;
  end

  // Main FSM, shared latency/beat counter, line assembly and statistics.
  // The visible line only changes on the final capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      word_idx         <= '0;
      wdata_q          <= '0;
      op_read          <= 1'b0;
      line_q           <= '0;
      main_mem_data_in <= '0;
      rd_count         <= '0;
      wr_count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (main_mem_read_req) begin
            word_idx <= req_idx;
            op_read  <= 1'b1;
            state    <= RD_WAIT;
          end else if (main_mem_write_req) begin
            word_idx <= req_idx;
            wdata_q  <= main_mem_data_out;
            op_read  <= 1'b0;
            state    <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == LAST_WAIT) begin
            cnt   <= '0;
            state <= RD_BURST;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RD_BURST: begin
          if (cnt != 16'd0) begin
            line_q <= line_next;
          end
          if (cnt == LAST_BEAT) begin
            main_mem_data_in <= line_next;
            cnt              <= '0;
            state            <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == LAST_WAIT) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (op_read) begin
            rd_count <= rd_count + 16'd1;
          end else begin
            wr_count <= wr_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder
// Self-checking bench for main_mem_responder: directed scenarios followed by
// random reads/writes, compared against a word-array model of the memory.
module tb_main_mem_responder;

  localparam int          DEPTH = 4096;
  localparam int          LAT   = 4;
  localparam logic [31:0] INIT  = 32'h0000_0002;

  logic         clk;
  logic         rst_n;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;
  logic         busy;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0]  ref_mem [DEPTH];
  logic [511:0] exp_line;
  int           exp_rd;
  int           exp_wr;

  main_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .INIT_WORD   (INIT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .main_mem_addr      (main_mem_addr),
    .main_mem_data_out  (main_mem_data_out),
    .main_mem_read_req  (main_mem_read_req),
    .main_mem_write_req (main_mem_write_req),
    .main_mem_data_in   (main_mem_data_in),
    .main_mem_ready     (main_mem_ready),
    .busy               (busy),
    .rd_count           (rd_count),
    .wr_count           (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    main_mem_read_req  = rd;
    main_mem_write_req = wr;
    main_mem_addr      = a;
    main_mem_data_out  = d;
  endtask

  function automatic int modelIndex(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [511:0] modelLine(input logic [31:0] a);
    logic [511:0] l;
    int idx;
    int base;
    idx  = modelIndex(a);
    base = idx - (idx % 16);
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = ref_mem[base + i];
    return l;
  endfunction

  // One complete transaction, started at a negedge in an idle cycle.
  task automatic transact(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          input bit hold, input string tag);
    int cycles;
    int exp_cycles;
    applyStimulus(rd, wr, a, d);
    cycles = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput({tag, " busy"}, 512'(busy), 512'(1'b1));
        checkOutput({tag, " held line"}, main_mem_data_in, exp_line);
        if (scramble) applyStimulus(1'b0, 1'b0, $urandom, $urandom);
      end
      if (main_mem_ready === 1'b1) begin
        cycles = c;
        break;
      end
    end
    exp_cycles = rd ? LAT + 18 : LAT + 1;
    checkOutput({tag, " ready cycle"}, 512'(cycles), 512'(exp_cycles));
    if (rd) begin
      exp_line = modelLine(a);
      exp_rd++;
    end else begin
      ref_mem[modelIndex(a)] = d;
      exp_wr++;
    end
    checkOutput({tag, " line"}, main_mem_data_in, exp_line);
    if (!hold) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, " ready pulse"}, 512'(main_mem_ready), 512'(1'b0));
    checkOutput({tag, " idle"}, 512'(busy), 512'(1'b0));
    checkOutput({tag, " rd_count"}, 512'(rd_count), 512'(16'(exp_rd)));
    checkOutput({tag, " wr_count"}, 512'(wr_count), 512'(16'(exp_wr)));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    int op;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
    exp_line = '0;
    exp_rd   = 0;
    exp_wr   = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 512'(main_mem_ready), 512'(1'b0));
    checkOutput("reset busy", 512'(busy), 512'(1'b0));
    checkOutput("reset line", main_mem_data_in, 512'(0));
    checkOutput("reset rd_count", 512'(rd_count), 512'(0));
    checkOutput("reset wr_count", 512'(wr_count), 512'(0));
    rst_n = 1'b1;

    // First line fill from untouched RAM.
    transact(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, "read40");
    checkOutput("read40 init words", main_mem_data_in, {16{INIT}});

    // Write-through then refill of the same line.
    transact(1'b0, 1'b1, 32'h0000_0084, 32'hDEAD_BEEF, 1'b0, 1'b0, "write84");
    transact(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, "read80");
    checkOutput("read80 word1", 512'(main_mem_data_in[63:32]), 512'(32'hDEAD_BEEF));
    checkOutput("read80 word0", 512'(main_mem_data_in[31:0]), 512'(INIT));

    // Simultaneous requests: read wins, write never lands.
    transact(1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0, 1'b0, "both");
    transact(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 1'b0, "both reread");
    checkOutput("both no write", 512'(main_mem_data_in[63:32]), 512'(INIT));

    // Address beyond the depth aliases onto the low words.
    transact(1'b0, 1'b1, 32'h0000_4004, 32'hA5A5_1234, 1'b0, 1'b0, "alias wr");
    transact(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, "alias rd");
    checkOutput("alias word1", 512'(main_mem_data_in[63:32]), 512'(32'hA5A5_1234));

    // Reset in the last wait cycle of a write drops the write.
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      checkOutput("rstwr no ready", 512'(main_mem_ready), 512'(1'b0));
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rstwr ready", 512'(main_mem_ready), 512'(1'b0));
    checkOutput("rstwr busy", 512'(busy), 512'(1'b0));
    checkOutput("rstwr line", main_mem_data_in, 512'(0));
    checkOutput("rstwr rd_count", 512'(rd_count), 512'(0));
    checkOutput("rstwr wr_count", 512'(wr_count), 512'(0));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_line = '0;
    exp_rd   = 0;
    exp_wr   = 0;
    transact(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, "rstwr reread");
    checkOutput("rstwr old word", 512'(main_mem_data_in[31:0]), 512'(INIT));

    // Request held through ready restarts after one idle cycle.
    transact(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b1, "b2b first");
    transact(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, "b2b second");

    // Random mix over a small window with varying alias bits.
    for (int n = 0; n < 40; n++) begin
      op   = int'($urandom_range(0, 1));
      ra   = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 127)) << 2)
             | 32'($urandom_range(0, 3));
      rdat = $urandom;
      transact(op == 1, op == 0, ra, rdat, 1'b1, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
